// File: rtl/toy_mem_pkg.sv
// Shared types and helpers for the RISC_TOY memory responder.
// Word/address widths, data-port payload, port-B operation codes and the range check.
package toy_mem_pkg;

    localparam int unsigned TOY_XLEN = 32;
    localparam int unsigned TOY_WAW  = 30;

    localparam logic DRW_WRITE = 1'b1;
    localparam logic DRW_READ  = 1'b0;

    typedef logic [TOY_XLEN-1:0] toy_word_t;
    typedef logic [TOY_WAW-1:0]  toy_waddr_t;

    // Data-port request as presented by the core in one cycle.
    typedef struct packed {
        logic       req;
        logic       rw;
        toy_waddr_t addr;
        toy_word_t  wdata;
    } toy_dreq_t;

    // Port-B command: PB_ZERO loads a zero read result for an out-of-range read.
    typedef enum logic [1:0] {
        PB_IDLE  = 2'd0,
        PB_READ  = 2'd1,
        PB_WRITE = 2'd2,
        PB_ZERO  = 2'd3
    } pb_op_t;

    // True when the word address is backed by storage (no aliasing above 2**aw).
    function automatic logic addr_in_range(input toy_waddr_t addr, input int unsigned aw);
        return (aw >= TOY_WAW) || ((addr >> aw) == '0);
    endfunction

endpackage

// File: rtl/toy_sram_1r1rw.sv
// DEPTH x 32 storage with a registered read port A and a registered read/write port B.
// Read results hold until the next enabled access; the array itself is never reset.
module toy_sram_1r1rw
    import toy_mem_pkg::*;
#(
    parameter int unsigned AW = 12
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                a_en,
    input  logic                a_clr,
    input  logic [AW-1:0]       a_addr,
    output logic [TOY_XLEN-1:0] a_rdata,
    input  pb_op_t              b_op,
    input  logic [AW-1:0]       b_addr,
    input  logic [TOY_XLEN-1:0] b_wdata,
    output logic [TOY_XLEN-1:0] b_rdata
);

    localparam int unsigned DEPTH = 2**AW;

    toy_word_t mem [DEPTH];

    // Nonblocking update keeps a same-edge port-A read on the old contents.
    always_ff @(posedge CLK) begin
        if (b_op == PB_WRITE) begin
            mem[b_addr] <= b_wdata;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            a_rdata <= '0;
        end else if (a_clr) begin
            a_rdata <= '0;
        end else if (a_en) begin
            a_rdata <= mem[a_addr];
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            b_rdata <= '0;
        end else if (b_op == PB_ZERO) begin
            b_rdata <= '0;
        end else if (b_op == PB_READ) begin
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/toy_mem_responder.sv
// Memory-side responder for the RISC_TOY instruction and data ports.
// Adds range checking, preload priority, sticky error flags and saturating access counters.
module toy_mem_responder
    import toy_mem_pkg::*;
#(
    parameter int unsigned AW    = 12,
    parameter int unsigned CNT_W = 32
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                IREQ,
    input  logic [TOY_WAW-1:0]  IADDR,
    output logic [TOY_XLEN-1:0] INSTR,
    input  logic                DREQ,
    input  logic                DRW,
    input  logic [TOY_WAW-1:0]  DADDR,
    input  logic [TOY_XLEN-1:0] DWDATA,
    output logic [TOY_XLEN-1:0] DRDATA,
    input  logic                LD_EN,
    input  logic [AW-1:0]       LD_ADDR,
    input  logic [TOY_XLEN-1:0] LD_DATA,
    output logic                IERR,
    output logic                DERR,
    output logic [CNT_W-1:0]    IFETCH_CNT,
    output logic [CNT_W-1:0]    DRD_CNT,
    output logic [CNT_W-1:0]    DWR_CNT
);

    toy_dreq_t      dreq;
    logic           fetch_ok;
    logic           data_ok;
    logic           data_acc;
    logic           data_rd;
    logic           data_wr;
    logic           fetch_en;
    logic           fetch_clr;
    pb_op_t         b_op;
    logic [AW-1:0]  b_addr;
    toy_word_t      b_wdata;

    assign dreq.req   = DREQ;
    assign dreq.rw    = DRW;
    assign dreq.addr  = DADDR;
    assign dreq.wdata = DWDATA;

    // Request decode; a preload takes the data port and silences any data request.
    always_comb begin
        fetch_ok  = addr_in_range(IADDR, AW);
        data_ok   = addr_in_range(dreq.addr, AW);
        fetch_en  = IREQ && fetch_ok;
        fetch_clr = IREQ && !fetch_ok;
        data_acc  = dreq.req && !LD_EN;
        data_rd   = data_acc && (dreq.rw == DRW_READ);
        data_wr   = data_acc && (dreq.rw == DRW_WRITE);
        b_op      = PB_IDLE;
        b_addr    = dreq.addr[AW-1:0];
        b_wdata   = dreq.wdata;
        if (LD_EN) begin
            b_op    = PB_WRITE;
            b_addr  = LD_ADDR;
            b_wdata = LD_DATA;
        end else if (data_rd) begin
            b_op = data_ok ? PB_READ : PB_ZERO;
        end else if (data_wr && data_ok) begin
            b_op = PB_WRITE;
        end
        if (!RSTN) begin
            b_op = PB_IDLE;
        end
    end

    toy_sram_1r1rw #(
        .AW (AW)
    ) u_sram (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .a_en    (fetch_en),
        .a_clr   (fetch_clr),
        .a_addr  (IADDR[AW-1:0]),
        .a_rdata (INSTR),
        .b_op    (b_op),
        .b_addr  (b_addr),
        .b_wdata (b_wdata),
        .b_rdata (DRDATA)
    );

    // Sticky range-error flags.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            IERR <= 1'b0;
            DERR <= 1'b0;
        end else begin
            if (fetch_clr) begin
                IERR <= 1'b1;
            end
            if (data_acc && !data_ok) begin
                DERR <= 1'b1;
            end
        end
    end

    // Issued-access counters, saturating at all-ones.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            IFETCH_CNT <= '0;
            DRD_CNT    <= '0;
            DWR_CNT    <= '0;
        end else begin
            if (IREQ && !(&IFETCH_CNT)) begin
                IFETCH_CNT <= IFETCH_CNT + CNT_W'(1);
            end
            if (data_rd && !(&DRD_CNT)) begin
                DRD_CNT <= DRD_CNT + CNT_W'(1);
            end
            if (data_wr && !(&DWR_CNT)) begin
                DWR_CNT <= DWR_CNT + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_toy_mem_responder.sv
// Self-checking bench for toy_mem_responder: directed scenarios plus a randomized run
// compared cycle by cycle against an array-based reference of the memory rules.
module tb_toy_mem_responder;

    localparam int unsigned AW    = 12;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CNT_W = 8;

    logic              clk;
    logic              rstn;
    logic              ireq;
    logic [29:0]       iaddr;
    logic [31:0]       instr;
    logic              dreq;
    logic              drw;
    logic [29:0]       daddr;
    logic [31:0]       dwdata;
    logic [31:0]       drdata;
    logic              ld_en;
    logic [AW-1:0]     ld_addr;
    logic [31:0]       ld_data;
    logic              ierr;
    logic              derr;
    logic [CNT_W-1:0]  fcnt;
    logic [CNT_W-1:0]  rcnt;
    logic [CNT_W-1:0]  wcnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state.
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_instr;
    logic [31:0] exp_drdata;
    logic        exp_ierr;
    logic        exp_derr;
    int          exp_fcnt;
    int          exp_rcnt;
    int          exp_wcnt;
    int          cnt_max;

    toy_mem_responder #(
        .AW    (AW),
        .CNT_W (CNT_W)
    ) dut (
        .CLK        (clk),
        .RSTN       (rstn),
        .IREQ       (ireq),
        .IADDR      (iaddr),
        .INSTR      (instr),
        .DREQ       (dreq),
        .DRW        (drw),
        .DADDR      (daddr),
        .DWDATA     (dwdata),
        .DRDATA     (drdata),
        .LD_EN      (ld_en),
        .LD_ADDR    (ld_addr),
        .LD_DATA    (ld_data),
        .IERR       (ierr),
        .DERR       (derr),
        .IFETCH_CNT (fcnt),
        .DRD_CNT    (rcnt),
        .DWR_CNT    (wcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        exp_instr  = '0;
        exp_drdata = '0;
        exp_ierr   = 1'b0;
        exp_derr   = 1'b0;
        exp_fcnt   = 0;
        exp_rcnt   = 0;
        exp_wcnt   = 0;
    endtask

    // One clock edge of the specified behaviour: all reads see memory before any write.
    task automatic model_edge();
        if (ireq) begin
            if (exp_fcnt < cnt_max) exp_fcnt++;
            if (iaddr >= 30'(DEPTH)) begin
                exp_instr = 32'h0;
                exp_ierr  = 1'b1;
            end else begin
                exp_instr = ref_mem[iaddr[AW-1:0]];
            end
        end
        if (ld_en) begin
            ref_mem[ld_addr] = ld_data;
        end else if (dreq) begin
            if (daddr >= 30'(DEPTH)) exp_derr = 1'b1;
            if (drw) begin
                if (exp_wcnt < cnt_max) exp_wcnt++;
                if (daddr < 30'(DEPTH)) ref_mem[daddr[AW-1:0]] = dwdata;
            end else begin
                if (exp_rcnt < cnt_max) exp_rcnt++;
                exp_drdata = (daddr < 30'(DEPTH)) ? ref_mem[daddr[AW-1:0]] : 32'h0;
            end
        end
    endtask

    task automatic idle_inputs();
        ireq    = 1'b0;
        iaddr   = '0;
        dreq    = 1'b0;
        drw     = 1'b0;
        daddr   = '0;
        dwdata  = '0;
        ld_en   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
    endtask

    // Advance one clock; the model only moves while reset is released.
    task automatic cycle();
        @(posedge clk);
        if (rstn) model_edge();
        #1;
    endtask

    task automatic preload(input int unsigned a, input logic [31:0] d);
        idle_inputs();
        ld_en   = 1'b1;
        ld_addr = AW'(a);
        ld_data = d;
        cycle();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (instr !== 32'h0) $display("FAIL reset_instr: got %h want %h", instr, 32'h0); else n_pass++;
        n_checks++; if (drdata !== 32'h0) $display("FAIL reset_drdata: got %h want %h", drdata, 32'h0); else n_pass++;
        n_checks++; if (ierr !== 1'b0) $display("FAIL reset_ierr: got %b want 0", ierr); else n_pass++;
        n_checks++; if (derr !== 1'b0) $display("FAIL reset_derr: got %b want 0", derr); else n_pass++;
        n_checks++; if (fcnt !== '0) $display("FAIL reset_fcnt: got %0d want 0", fcnt); else n_pass++;
        n_checks++; if (rcnt !== '0) $display("FAIL reset_rcnt: got %0d want 0", rcnt); else n_pass++;
        n_checks++; if (wcnt !== '0) $display("FAIL reset_wcnt: got %0d want 0", wcnt); else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        #1;
    endtask

    task automatic test_preload_all();
        for (int i = 0; i < int'(DEPTH); i++) begin
            preload(i, $urandom);
        end
        n_checks++; if (wcnt !== '0) $display("FAIL preload_wcnt: got %0d want 0", wcnt); else n_pass++;
        n_checks++; if (drdata !== 32'h0) $display("FAIL preload_drdata: got %h want %h", drdata, 32'h0); else n_pass++;
    endtask

    task automatic test_fetch_seq();
        logic [31:0] want [4];
        want[0] = 32'd11; want[1] = 32'd22; want[2] = 32'd33; want[3] = 32'd44;
        for (int i = 0; i < 4; i++) preload(i, want[i]);
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            ireq  = 1'b1;
            iaddr = 30'(i);
            cycle();
            n_checks++; if (instr !== want[i]) $display("FAIL fetch_seq_%0d: got %h want %h", i, instr, want[i]); else n_pass++;
        end
        idle_inputs();
        n_checks++; if (fcnt !== CNT_W'(4)) $display("FAIL fetch_seq_cnt: got %0d want 4", fcnt); else n_pass++;
    endtask

    task automatic test_write_read();
        idle_inputs();
        dreq = 1'b1; drw = 1'b1; daddr = 30'd5; dwdata = 32'hDEADBEEF;
        cycle();
        idle_inputs();
        dreq = 1'b1; drw = 1'b0; daddr = 30'd5;
        cycle();
        idle_inputs();
        n_checks++; if (drdata !== 32'hDEADBEEF) $display("FAIL write_read_data: got %h want %h", drdata, 32'hDEADBEEF); else n_pass++;
        n_checks++; if (wcnt !== CNT_W'(1)) $display("FAIL write_read_wcnt: got %0d want 1", wcnt); else n_pass++;
        n_checks++; if (rcnt !== CNT_W'(1)) $display("FAIL write_read_rcnt: got %0d want 1", rcnt); else n_pass++;
    endtask

    task automatic test_collision();
        preload(7, 32'hAAAA);
        ireq = 1'b1; iaddr = 30'd7;
        dreq = 1'b1; drw = 1'b1; daddr = 30'd7; dwdata = 32'h1234;
        cycle();
        idle_inputs();
        n_checks++; if (instr !== 32'hAAAA) $display("FAIL collision_old: got %h want %h", instr, 32'hAAAA); else n_pass++;
        ireq = 1'b1; iaddr = 30'd7;
        cycle();
        idle_inputs();
        n_checks++; if (instr !== 32'h1234) $display("FAIL collision_new: got %h want %h", instr, 32'h1234); else n_pass++;
    endtask

    task automatic test_out_of_range();
        dreq = 1'b1; drw = 1'b0; daddr = 30'(DEPTH);
        cycle();
        idle_inputs();
        n_checks++; if (drdata !== 32'h0) $display("FAIL oor_read_data: got %h want %h", drdata, 32'h0); else n_pass++;
        n_checks++; if (derr !== 1'b1) $display("FAIL oor_derr_set: got %b want 1", derr); else n_pass++;
        cycle();
        n_checks++; if (derr !== 1'b1) $display("FAIL oor_derr_sticky: got %b want 1", derr); else n_pass++;
        dreq = 1'b1; drw = 1'b1; daddr = 30'(DEPTH + 1); dwdata = 32'hBADBAD01;
        cycle();
        dreq = 1'b1; drw = 1'b0; daddr = 30'd1;
        cycle();
        idle_inputs();
        n_checks++; if (drdata !== 32'd22) $display("FAIL oor_write_dropped: got %h want %h", drdata, 32'd22); else n_pass++;
        dreq = 1'b1; drw = 1'b0; daddr = 30'h2000_0005;
        cycle();
        idle_inputs();
        n_checks++; if (drdata !== 32'h0) $display("FAIL oor_no_alias: got %h want %h", drdata, 32'h0); else n_pass++;
        ireq = 1'b1; iaddr = 30'h3FFF_FFFF;
        cycle();
        idle_inputs();
        n_checks++; if (instr !== 32'h0) $display("FAIL oor_fetch_data: got %h want %h", instr, 32'h0); else n_pass++;
        n_checks++; if (ierr !== 1'b1) $display("FAIL oor_ierr: got %b want 1", ierr); else n_pass++;
    endtask

    task automatic test_preload_priority();
        logic [CNT_W-1:0] wcnt_before;
        logic [CNT_W-1:0] rcnt_before;
        wcnt_before = CNT_W'(exp_wcnt);
        ld_en = 1'b1; ld_addr = AW'(9); ld_data = 32'hCAFE0009;
        dreq = 1'b1; drw = 1'b1; daddr = 30'd9; dwdata = 32'h5555;
        cycle();
        idle_inputs();
        n_checks++; if (wcnt !== wcnt_before) $display("FAIL prio_wcnt: got %0d want %0d", wcnt, wcnt_before); else n_pass++;
        dreq = 1'b1; drw = 1'b0; daddr = 30'd9;
        cycle();
        idle_inputs();
        n_checks++; if (drdata !== 32'hCAFE0009) $display("FAIL prio_mem9: got %h want %h", drdata, 32'hCAFE0009); else n_pass++;
        rcnt_before = CNT_W'(exp_rcnt);
        ld_en = 1'b1; ld_addr = AW'(100); ld_data = 32'h0000_0100;
        dreq = 1'b1; drw = 1'b0; daddr = 30'd5;
        cycle();
        idle_inputs();
        n_checks++; if (drdata !== 32'hCAFE0009) $display("FAIL prio_drdata_hold: got %h want %h", drdata, 32'hCAFE0009); else n_pass++;
        n_checks++; if (rcnt !== rcnt_before) $display("FAIL prio_rcnt: got %0d want %0d", rcnt, rcnt_before); else n_pass++;
    endtask

    task automatic test_hold();
        logic [31:0] instr_before;
        instr_before = exp_instr;
        ireq = 1'b0; iaddr = 30'($urandom);
        dreq = 1'b0; drw = 1'b1; daddr = 30'd9; dwdata = 32'h0;
        cycle();
        idle_inputs();
        n_checks++; if (instr !== instr_before) $display("FAIL hold_instr: got %h want %h", instr, instr_before); else n_pass++;
        ireq = 1'b1; iaddr = 30'd9;
        cycle();
        idle_inputs();
        n_checks++; if (instr !== 32'hCAFE0009) $display("FAIL hold_no_write: got %h want %h", instr, 32'hCAFE0009); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] keep20;
        keep20 = ref_mem[20];
        ireq = 1'b1; iaddr = 30'd3;
        dreq = 1'b1; drw = 1'b1; daddr = 30'd20; dwdata = 32'h0BAD0BAD;
        rstn = 1'b0;
        model_reset();
        #1;
        n_checks++; if (instr !== 32'h0) $display("FAIL rst_mid_instr: got %h want %h", instr, 32'h0); else n_pass++;
        n_checks++; if (drdata !== 32'h0) $display("FAIL rst_mid_drdata: got %h want %h", drdata, 32'h0); else n_pass++;
        n_checks++; if (ierr !== 1'b0 || derr !== 1'b0) $display("FAIL rst_mid_flags: got %b%b want 00", ierr, derr); else n_pass++;
        n_checks++; if (fcnt !== '0 || rcnt !== '0 || wcnt !== '0) $display("FAIL rst_mid_cnts: got %0d/%0d/%0d want 0/0/0", fcnt, rcnt, wcnt); else n_pass++;
        cycle();
        cycle();
        n_checks++; if (instr !== 32'h0 || wcnt !== '0) $display("FAIL rst_held: got %h/%0d want 0/0", instr, wcnt); else n_pass++;
        @(negedge clk);
        idle_inputs();
        rstn = 1'b1;
        #1;
        dreq = 1'b1; drw = 1'b0; daddr = 30'd20;
        cycle();
        idle_inputs();
        n_checks++; if (drdata !== keep20) $display("FAIL rst_mem_kept: got %h want %h", drdata, keep20); else n_pass++;
        n_checks++; if (rcnt !== CNT_W'(1)) $display("FAIL rst_rcnt_restart: got %0d want 1", rcnt); else n_pass++;
        ireq = 1'b1; iaddr = 30'd2;
        cycle();
        idle_inputs();
        n_checks++; if (instr !== 32'd33) $display("FAIL rst_mem_kept_fetch: got %h want %h", instr, 32'd33); else n_pass++;
    endtask

    function automatic logic [29:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return 30'($urandom) | 30'(DEPTH);
        return 30'($urandom_range(0, 63));
    endfunction

    task automatic test_random();
        for (int n = 0; n < 1200; n++) begin
            ireq    = 1'($urandom_range(0, 1));
            iaddr   = rand_addr();
            dreq    = 1'($urandom_range(0, 1));
            drw     = 1'($urandom_range(0, 1));
            daddr   = rand_addr();
            dwdata  = $urandom;
            ld_en   = ($urandom_range(0, 9) == 0);
            ld_addr = AW'($urandom_range(0, 63));
            ld_data = $urandom;
            cycle();
            n_checks++; if (instr !== exp_instr) $display("FAIL rand_instr @%0d: got %h want %h", n, instr, exp_instr); else n_pass++;
            n_checks++; if (drdata !== exp_drdata) $display("FAIL rand_drdata @%0d: got %h want %h", n, drdata, exp_drdata); else n_pass++;
            n_checks++; if (ierr !== exp_ierr) $display("FAIL rand_ierr @%0d: got %b want %b", n, ierr, exp_ierr); else n_pass++;
            n_checks++; if (derr !== exp_derr) $display("FAIL rand_derr @%0d: got %b want %b", n, derr, exp_derr); else n_pass++;
            n_checks++; if (fcnt !== CNT_W'(exp_fcnt)) $display("FAIL rand_fcnt @%0d: got %0d want %0d", n, fcnt, exp_fcnt); else n_pass++;
            n_checks++; if (rcnt !== CNT_W'(exp_rcnt)) $display("FAIL rand_rcnt @%0d: got %0d want %0d", n, rcnt, exp_rcnt); else n_pass++;
            n_checks++; if (wcnt !== CNT_W'(exp_wcnt)) $display("FAIL rand_wcnt @%0d: got %0d want %0d", n, wcnt, exp_wcnt); else n_pass++;
        end
        idle_inputs();
        n_checks++; if (fcnt !== {CNT_W{1'b1}}) $display("FAIL rand_fcnt_saturated: got %0d want %0d", fcnt, cnt_max); else n_pass++;
    endtask

    initial begin
        cnt_max = (1 << CNT_W) - 1;
        rstn = 1'b0;
        idle_inputs();
        test_reset();
        test_preload_all();
        test_fetch_seq();
        test_write_read();
        test_collision();
        test_out_of_range();
        test_preload_priority();
        test_hold();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
